// File: rtl/alarm_ring_ctrl.sv
// Alarm sequencer: compares running time with the active target and drives the buzzer
// through ring, auto-timeout, snooze and dismiss.
module alarm_ring_ctrl #(
   parameter int RING_SECONDS   = 60,
   parameter int SNOOZE_MINUTES = 5,
   parameter int BEEP_HALF      = 25_000_000
) (
   input  logic       clk,
   input  logic       rst_n,
   input  logic       sec_tick,
   input  logic [4:0] cur_hr,
   input  logic [5:0] cur_min,
   input  logic [5:0] cur_sec,
   input  logic [4:0] alm_hr,
   input  logic [5:0] alm_min,
   input  logic       alarm_on,
   input  logic       setting_active,
   input  logic       dismiss,
   input  logic       snooze,
   output logic       buzzer,
   output logic       ringing,
   output logic       snoozed,
   output logic [4:0] tgt_hr,
   output logic [5:0] tgt_min,
   output logic [1:0] state_dbg
);

   typedef enum logic [1:0] {
      IDLE    = 2'd0,
      ARMED   = 2'd1,
      RINGING = 2'd2,
      SNOOZE  = 2'd3
   } state_t;

   localparam int BW = $clog2(BEEP_HALF) + 1;

   state_t        state_q, state_d;
   logic          match_q;
   logic          from_snz_q, from_snz_d;
   logic [5:0]    ring_cnt_q, ring_cnt_d;
   logic [BW-1:0] beep_cnt_q, beep_cnt_d;
   logic          buzzer_q, buzzer_d;
   logic [4:0]    snz_hr_q, snz_hr_d;
   logic [5:0]    snz_min_q, snz_min_d;

   logic       match, hit, use_snz, entering;
   logic [6:0] m_sum;
   logic [4:0] h_inc;

   // The target follows the snooze time while waiting on, or ringing from, a snooze.
   assign use_snz = (state_q == SNOOZE) || ((state_q == RINGING) && from_snz_q);
   assign match   = (cur_hr == tgt_hr) && (cur_min == tgt_min) && (cur_sec == 6'd0)
                    && !setting_active;
   assign hit     = match && !match_q;

   assign m_sum = {1'b0, cur_min} + 7'(SNOOZE_MINUTES);
   assign h_inc = (cur_hr == 5'd23) ? 5'd0 : cur_hr + 5'd1;

   // State register and datapath registers
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q    <= IDLE;
         match_q    <= 1'b0;
         from_snz_q <= 1'b0;
         ring_cnt_q <= '0;
         beep_cnt_q <= '0;
         buzzer_q   <= 1'b0;
         snz_hr_q   <= '0;
         snz_min_q  <= '0;
      end else begin
         state_q    <= state_d;
         match_q    <= match;
         from_snz_q <= from_snz_d;
         ring_cnt_q <= ring_cnt_d;
         beep_cnt_q <= beep_cnt_d;
         buzzer_q   <= buzzer_d;
         snz_hr_q   <= snz_hr_d;
         snz_min_q  <= snz_min_d;
      end
   end

   // Next-state logic
   always_comb begin
      state_d    = state_q;
      from_snz_d = from_snz_q;
      snz_hr_d   = snz_hr_q;
      snz_min_d  = snz_min_q;
      if (!alarm_on) begin
         state_d = IDLE;
      end else begin
         unique case (state_q)
            IDLE:  state_d = ARMED;
            ARMED: begin
               if (hit) begin
                  state_d    = RINGING;
                  from_snz_d = 1'b0;
               end
            end
            RINGING: begin
               if (setting_active) begin
                  state_d = ARMED;
               end else if (dismiss) begin
                  state_d = ARMED;
               end else if (snooze) begin
                  state_d = SNOOZE;
                  if (m_sum >= 7'd60) begin
                     snz_min_d = 6'(m_sum - 7'd60);
                     snz_hr_d  = h_inc;
                  end else begin
                     snz_min_d = m_sum[5:0];
                     snz_hr_d  = cur_hr;
                  end
               end else if (ring_cnt_q == 6'(RING_SECONDS)) begin
                  state_d = ARMED;
               end
            end
            SNOOZE: begin
               if (setting_active || dismiss) begin
                  state_d = ARMED;
               end else if (hit) begin
                  state_d    = RINGING;
                  from_snz_d = 1'b1;
               end
            end
            default: state_d = IDLE;
         endcase
      end
   end

   // Ring counter and buzzer square wave restart on every entry to RINGING.
   assign entering = (state_d == RINGING) && (state_q != RINGING);

   always_comb begin
      ring_cnt_d = ring_cnt_q;
      beep_cnt_d = beep_cnt_q;
      buzzer_d   = 1'b0;
      if (entering) begin
         ring_cnt_d = '0;
         beep_cnt_d = '0;
         buzzer_d   = 1'b1;
      end else if (state_d == RINGING) begin
         if (sec_tick && (ring_cnt_q != 6'h3f)) ring_cnt_d = ring_cnt_q + 6'd1;
         if (beep_cnt_q == BW'(BEEP_HALF - 1)) begin
            beep_cnt_d = '0;
            buzzer_d   = ~buzzer_q;
         end else begin
            beep_cnt_d = beep_cnt_q + BW'(1);
            buzzer_d   = buzzer_q;
         end
      end
   end

   // Output decode
   always_comb begin
      ringing   = (state_q == RINGING);
      snoozed   = (state_q == SNOOZE);
      buzzer    = buzzer_q;
      state_dbg = state_q;
      tgt_hr    = use_snz ? snz_hr_q  : alm_hr;
      tgt_min   = use_snz ? snz_min_q : alm_min;
   end

endmodule

// File: tb/tb_alarm_ring_ctrl.sv
// Directed bench for alarm_ring_ctrl with RING_SECONDS=3, SNOOZE_MINUTES=5, BEEP_HALF=4.
module tb_alarm_ring_ctrl;

  localparam logic [1:0] S_IDLE = 2'd0, S_ARMED = 2'd1, S_RING = 2'd2, S_SNZ = 2'd3;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic       sec_tick = 1'b0;
  logic [4:0] cur_hr = '0;
  logic [5:0] cur_min = '0;
  logic [5:0] cur_sec = '0;
  logic [4:0] alm_hr = '0;
  logic [5:0] alm_min = '0;
  logic       alarm_on = 1'b0;
  logic       setting_active = 1'b0;
  logic       dismiss = 1'b0;
  logic       snooze = 1'b0;
  logic       buzzer, ringing, snoozed;
  logic [4:0] tgt_hr;
  logic [5:0] tgt_min;
  logic [1:0] state_dbg;

  int total = 0;
  int bad = 0;

  alarm_ring_ctrl #(
    .RING_SECONDS(3),
    .SNOOZE_MINUTES(5),
    .BEEP_HALF(4)
  ) dut (
    .clk(clk), .rst_n(rst_n), .sec_tick(sec_tick),
    .cur_hr(cur_hr), .cur_min(cur_min), .cur_sec(cur_sec),
    .alm_hr(alm_hr), .alm_min(alm_min),
    .alarm_on(alarm_on), .setting_active(setting_active),
    .dismiss(dismiss), .snooze(snooze),
    .buzzer(buzzer), .ringing(ringing), .snoozed(snoozed),
    .tgt_hr(tgt_hr), .tgt_min(tgt_min), .state_dbg(state_dbg)
  );

  // clock / reset
  always #5 clk = ~clk;

  // driver tasks
  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic set_time(input logic [4:0] h, input logic [5:0] m, input logic [5:0] s);
    cur_hr = h; cur_min = m; cur_sec = s;
  endtask

  task automatic tick();
    sec_tick = 1'b1;
    step();
    sec_tick = 1'b0;
  endtask

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  initial begin
    // reset state
    #12;
    check("rst_ringing", 32'(ringing), 32'd0);
    check("rst_buzzer", 32'(buzzer), 32'd0);
    check("rst_snoozed", 32'(snoozed), 32'd0);
    check("rst_state", 32'(state_dbg), 32'(S_IDLE));
    rst_n = 1'b1;
    step();

    // arm with alarm at 07:30
    alm_hr = 5'd7; alm_min = 6'd30;
    set_time(5'd7, 6'd29, 6'd59);
    alarm_on = 1'b1;
    step();
    check("arm_state", 32'(state_dbg), 32'(S_ARMED));
    check("arm_tgt", {21'd0, tgt_hr, tgt_min}, {21'd0, 5'd7, 6'd30});
    step();
    check("arm_noring", 32'(ringing), 32'd0);

    // time reaches 07:30:00 -> ring, buzzer 1,1,1,1,0,0,0,0
    set_time(5'd7, 6'd30, 6'd0);
    step();
    check("ring_start", 32'(ringing), 32'd1);
    for (int i = 0; i < 8; i++) begin
      check($sformatf("beep_%0d", i), 32'(buzzer), (i < 4) ? 32'd1 : 32'd0);
      step();
    end
    check("beep_wrap", 32'(buzzer), 32'd1);

    // auto-stop after 3 seconds of ringing
    tick(); tick(); tick();
    check("auto_still", 32'(ringing), 32'd1);
    step();
    check("auto_ringing", 32'(ringing), 32'd0);
    check("auto_buzzer", 32'(buzzer), 32'd0);
    check("auto_state", 32'(state_dbg), 32'(S_ARMED));
    step(); step(); step();
    check("no_rering", 32'(ringing), 32'd0);

    // snooze across midnight: 23:58 + 5 -> 00:03
    alm_hr = 5'd23; alm_min = 6'd58;
    set_time(5'd23, 6'd57, 6'd59);
    step();
    set_time(5'd23, 6'd58, 6'd0);
    step();
    check("snz_ring", 32'(ringing), 32'd1);
    snooze = 1'b1;
    step();
    snooze = 1'b0;
    check("snz_snoozed", 32'(snoozed), 32'd1);
    check("snz_ringing", 32'(ringing), 32'd0);
    check("snz_buzzer", 32'(buzzer), 32'd0);
    check("snz_tgt", {21'd0, tgt_hr, tgt_min}, {21'd0, 5'd0, 6'd3});
    set_time(5'd0, 6'd2, 6'd59);
    step();
    check("snz_wait", 32'(state_dbg), 32'(S_SNZ));
    set_time(5'd0, 6'd3, 6'd0);
    step();
    check("snz_rering", 32'(ringing), 32'd1);
    check("snz_rering_buz", 32'(buzzer), 32'd1);
    check("snz_rering_tgt", {21'd0, tgt_hr, tgt_min}, {21'd0, 5'd0, 6'd3});

    // dismiss and snooze together -> dismiss wins
    dismiss = 1'b1; snooze = 1'b1;
    step();
    dismiss = 1'b0; snooze = 1'b0;
    check("both_state", 32'(state_dbg), 32'(S_ARMED));
    check("both_snoozed", 32'(snoozed), 32'd0);
    check("both_ringing", 32'(ringing), 32'd0);
    check("both_tgt", {21'd0, tgt_hr, tgt_min}, {21'd0, 5'd23, 6'd58});

    // alarm_on dropped mid-ring
    alm_hr = 5'd7; alm_min = 6'd30;
    set_time(5'd7, 6'd29, 6'd59);
    step();
    set_time(5'd7, 6'd30, 6'd0);
    step();
    check("off_ring", 32'(ringing), 32'd1);
    alarm_on = 1'b0;
    step();
    check("off_state", 32'(state_dbg), 32'(S_IDLE));
    check("off_buzzer", 32'(buzzer), 32'd0);
    alarm_on = 1'b1;
    step();
    check("reon_state", 32'(state_dbg), 32'(S_ARMED));
    step();
    check("reon_noring", 32'(ringing), 32'd0);

    // setting in progress blocks the match
    set_time(5'd7, 6'd29, 6'd59);
    step();
    setting_active = 1'b1;
    set_time(5'd7, 6'd30, 6'd0);
    step(); step();
    check("set_noring", 32'(ringing), 32'd0);
    set_time(5'd7, 6'd30, 6'd1);
    step();
    setting_active = 1'b0;
    step();
    check("set_after", 32'(ringing), 32'd0);

    // asynchronous reset while ringing
    set_time(5'd7, 6'd29, 6'd59);
    step();
    set_time(5'd7, 6'd30, 6'd0);
    step();
    check("arst_pre", 32'(ringing), 32'd1);
    #2;
    rst_n = 1'b0;
    #1;
    check("arst_ringing", 32'(ringing), 32'd0);
    check("arst_buzzer", 32'(buzzer), 32'd0);
    check("arst_snoozed", 32'(snoozed), 32'd0);
    check("arst_state", 32'(state_dbg), 32'(S_IDLE));
    #10;
    rst_n = 1'b1;
    step();

    // final report
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
